// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The state type and the two output bundles (normal flow and reset) live here.
package pipeline_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic pcWrite;
        logic ifIdWrite;
        logic ifIdFlush;
        logic idExWrite;
        logic idExFlush;
        logic exMemFlush;
        logic exMcDone;
    } ctrl_out_t;

    // Free-flowing pipeline: everything advances, nothing is flushed.
    localparam ctrl_out_t CTRL_DEFAULT = '{
        pcWrite:    1'b1,
        ifIdWrite:  1'b1,
        ifIdFlush:  1'b0,
        idExWrite:  1'b1,
        idExFlush:  1'b0,
        exMemFlush: 1'b0,
        exMcDone:   1'b0
    };

    // While reset is held: freeze all writes and bubble every stage.
    localparam ctrl_out_t CTRL_RESET = '{
        pcWrite:    1'b0,
        ifIdWrite:  1'b0,
        ifIdFlush:  1'b1,
        idExWrite:  1'b0,
        idExFlush:  1'b1,
        exMemFlush: 1'b1,
        exMcDone:   1'b0
    };

endpackage

// File: rtl/mc_stall_counter.sv
// Down-counter tracking how many stall cycles a multi-cycle EX op still needs.
// Supports load, decrement (saturating at zero) and zero detection.
module mc_stall_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load has priority over decrement; never wraps below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use stalls,
// taken-branch flushes and multi-cycle EX op stalls.
// Optional build macro HAZARD_STATS_EN adds saturating stall/flush counters.
// Note: rst_n is active-high despite its name.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W = pipeline_ctrl_pkg::REG_ADDR_W,
    parameter int MC_LATENCY = 4
`ifdef HAZARD_STATS_EN
    , parameter int STAT_W   = 32
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] idRs1,
    input  logic [REG_ADDR_W-1:0] idRs2,
    input  logic                  idUsesRs1,
    input  logic                  idUsesRs2,
    input  logic [REG_ADDR_W-1:0] exRd,
    input  logic                  exMemRead,
    input  logic                  exBranchTkn,
    input  logic                  exMcOp,
    output logic                  pcWrite,
    output logic                  ifIdWrite,
    output logic                  ifIdFlush,
    output logic                  idExWrite,
    output logic                  idExFlush,
    output logic                  exMemFlush,
    output logic                  exMcDone
`ifdef HAZARD_STATS_EN
    , output logic [STAT_W-1:0]   stallCnt
    , output logic [STAT_W-1:0]   flushCnt
`endif
);

    import pipeline_ctrl_pkg::*;

    localparam int CNT_W = $clog2(MC_LATENCY) + 1;
    localparam logic [CNT_W-1:0] MC_LOAD =
        (MC_LATENCY > 1) ? CNT_W'(MC_LATENCY - 2) : '0;

    state_e    state_q;
    state_e    state_d;
    ctrl_out_t ctrl;
    logic      loadUse;
    logic      mcLoad;
    logic      mcDec;
    logic      mcZero;

    assign loadUse = exMemRead && (exRd != '0) &&
                     (((exRd == idRs1) && idUsesRs1) ||
                      ((exRd == idRs2) && idUsesRs2));

    mc_stall_counter #(
        .CNT_W(CNT_W)
    ) u_mc_cnt (
        .clk       (clk),
        .rst       (rst_n),
        .load_i    (mcLoad),
        .load_val_i(MC_LOAD),
        .dec_i     (mcDec),
        .zero_o    (mcZero)
    );

    // Hazard resolution: chooses outputs and next state; branch > mc op > load-use in RUN.
    always_comb begin
        ctrl    = CTRL_DEFAULT;
        state_d = state_q;
        mcLoad  = 1'b0;
        mcDec   = 1'b0;
        if (rst_n) begin
            ctrl    = CTRL_RESET;
            state_d = RUN;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (exBranchTkn) begin
                        ctrl.ifIdFlush = 1'b1;
                        ctrl.idExFlush = 1'b1;
                    end else if (exMcOp) begin
                        if (MC_LATENCY > 1) begin
                            ctrl.pcWrite    = 1'b0;
                            ctrl.ifIdWrite  = 1'b0;
                            ctrl.idExWrite  = 1'b0;
                            ctrl.exMemFlush = 1'b1;
                            mcLoad          = 1'b1;
                            state_d         = MC_WAIT;
                        end else begin
                            ctrl.exMcDone = 1'b1;
                        end
                    end else if (loadUse) begin
                        ctrl.pcWrite   = 1'b0;
                        ctrl.ifIdWrite = 1'b0;
                        ctrl.idExFlush = 1'b1;
                    end
                end
                MC_WAIT: begin
                    if (!mcZero) begin
                        ctrl.pcWrite    = 1'b0;
                        ctrl.ifIdWrite  = 1'b0;
                        ctrl.idExWrite  = 1'b0;
                        ctrl.exMemFlush = 1'b1;
                        mcDec           = 1'b1;
                    end else begin
                        // Release cycle: op leaves EX; load-use checking is live again.
                        ctrl.exMcDone = 1'b1;
                        state_d       = RUN;
                        if (loadUse) begin
                            ctrl.pcWrite   = 1'b0;
                            ctrl.ifIdWrite = 1'b0;
                            ctrl.idExFlush = 1'b1;
                        end
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // State register; reset aborts any multi-cycle wait immediately.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign pcWrite    = ctrl.pcWrite;
    assign ifIdWrite  = ctrl.ifIdWrite;
    assign ifIdFlush  = ctrl.ifIdFlush;
    assign idExWrite  = ctrl.idExWrite;
    assign idExFlush  = ctrl.idExFlush;
    assign exMemFlush = ctrl.exMemFlush;
    assign exMcDone   = ctrl.exMcDone;

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] stallCnt_q;
    logic [STAT_W-1:0] flushCnt_q;

    // Saturating statistics counters for stall and flush cycles.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            if (!ctrl.pcWrite && (stallCnt_q != '1)) begin
                stallCnt_q <= stallCnt_q + 1'b1;
            end
            if ((ctrl.ifIdFlush || ctrl.idExFlush) && (flushCnt_q != '1)) begin
                flushCnt_q <= flushCnt_q + 1'b1;
            end
        end
    end

    assign stallCnt = stallCnt_q;
    assign flushCnt = flushCnt_q;
`endif

    // Multi-cycle ops never branch; a taken branch while waiting is a pipeline bug.
    a_no_branch_in_mc_wait: assert property (
        @(posedge clk) disable iff (rst_n) !((state_q == MC_WAIT) && exBranchTkn)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed hazard scenarios
// followed by randomized traffic against a cycle-age reference model.
module tb_pipeline_hazard_ctrl;

    localparam int LAT = 4;
    localparam int RW  = 5;
    localparam int SW  = 4;

    // Expected output vectors: {pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, exMemFlush, exMcDone}
    localparam logic [6:0] E_DEF   = 7'b1101000;
    localparam logic [6:0] E_RST   = 7'b0010110;
    localparam logic [6:0] E_MC    = 7'b0000010;
    localparam logic [6:0] E_LU    = 7'b0001100;
    localparam logic [6:0] E_BR    = 7'b1111100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [RW-1:0] idRs1, idRs2, exRd;
    logic          idUsesRs1, idUsesRs2, exMemRead, exBranchTkn, exMcOp;
    logic          pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, exMemFlush, exMcDone;
`ifdef HAZARD_STATS_EN
    logic [SW-1:0] stallCnt, flushCnt;
    int unsigned   stallM, flushM;
`endif

    int checks = 0;
    int errors = 0;
    int mcAge  = 0;     // cycles the current multi-cycle op has already spent in EX
    int doneObs = 0;    // exMcDone pulses seen on the DUT
    int stallObs = 0;   // cycles with pcWrite = 0 seen on the DUT (outside reset)

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W(RW),
        .MC_LATENCY(LAT)
`ifdef HAZARD_STATS_EN
        , .STAT_W(SW)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .idRs1      (idRs1),
        .idRs2      (idRs2),
        .idUsesRs1  (idUsesRs1),
        .idUsesRs2  (idUsesRs2),
        .exRd       (exRd),
        .exMemRead  (exMemRead),
        .exBranchTkn(exBranchTkn),
        .exMcOp     (exMcOp),
        .pcWrite    (pcWrite),
        .ifIdWrite  (ifIdWrite),
        .ifIdFlush  (ifIdFlush),
        .idExWrite  (idExWrite),
        .idExFlush  (idExFlush),
        .exMemFlush (exMemFlush),
        .exMcDone   (exMcDone)
`ifdef HAZARD_STATS_EN
        , .stallCnt (stallCnt)
        , .flushCnt (flushCnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, predict and compare outputs, advance the model.
    task automatic step(input logic r, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                        input logic u1, input logic u2, input logic [RW-1:0] rd,
                        input logic mr, input logic bt, input logic mc, input string tag);
        logic [6:0] exp;
        logic       lu;
        int         nextAge;
        rst_n = r; idRs1 = rs1; idRs2 = rs2; idUsesRs1 = u1; idUsesRs2 = u2;
        exRd = rd; exMemRead = mr; exBranchTkn = bt; exMcOp = mc;
        @(negedge clk);
        lu = mr && (rd != 0) && ((rd == rs1 && u1) || (rd == rs2 && u2));
        nextAge = mcAge;
        if (r) begin
            exp = E_RST;
            nextAge = 0;
        end else if (mcAge > 0) begin
            if (mcAge + 1 < LAT) begin
                exp = E_MC;
                nextAge = mcAge + 1;
            end else begin
                exp = lu ? E_LU : E_DEF;
                exp[0] = 1'b1;
                nextAge = 0;
            end
        end else if (bt) begin
            exp = E_BR;
        end else if (mc) begin
            if (LAT == 1) begin
                exp = E_DEF;
                exp[0] = 1'b1;
            end else begin
                exp = E_MC;
                nextAge = 1;
            end
        end else if (lu) begin
            exp = E_LU;
        end else begin
            exp = E_DEF;
        end
        check(tag, {57'd0, pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, exMemFlush, exMcDone},
              {57'd0, exp});
        if (exMcDone) doneObs++;
        if (!r && !pcWrite) stallObs++;
`ifdef HAZARD_STATS_EN
        if (r) begin
            stallM = 0;
            flushM = 0;
        end else begin
            if (!exp[6] && stallM < (2**SW - 1)) stallM++;
            if ((exp[4] || exp[2]) && flushM < (2**SW - 1)) flushM++;
        end
`endif
        @(posedge clk);
        mcAge = nextAge;
        #1;
`ifdef HAZARD_STATS_EN
        check({tag, "_stallCnt"}, {60'd0, stallCnt}, 64'(stallM));
        check({tag, "_flushCnt"}, {60'd0, flushCnt}, 64'(flushM));
`endif
    endtask

    task automatic idle(input string tag);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        int d0, s0;
        logic r, bt;
        #1;
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, "reset0");
        step(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, "reset1");

        // Load-use on rs1, then on rs2, each stalls exactly one cycle.
        step(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, "lu_rs1");
        step(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, "lu_after");
        step(1'b0, 5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, "lu_rs2");
        step(1'b0, 5'd7, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, "lu_unused");
        // x0 destination never stalls.
        step(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, "lu_x0");
        // Branch masks a simultaneous load-use.
        step(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, "br_lu");
        idle("br_after");

        // Multi-cycle op held for LAT cycles: LAT-1 stalls, then one done pulse.
        d0 = doneObs; s0 = stallObs;
        for (int unsigned i = 0; i < LAT; i++) begin
            step(1'b0, 5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, "mc_op");
        end
        check("mc_done_count", 64'(doneObs - d0), 64'd1);
        check("mc_stall_count", 64'(stallObs - s0), 64'(LAT - 1));
        idle("mc_after");

        // Reset in the second MC_WAIT cycle aborts the op without a done pulse.
        d0 = doneObs;
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, "abort_start");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, "abort_wait1");
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, "abort_rst");
        idle("abort_run0");
        idle("abort_run1");
        check("abort_no_done", 64'(doneObs - d0), 64'd0);

        // Randomized traffic with a narrow register range so hazards are frequent.
        for (int unsigned n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 63) == 0);
            bt = (mcAge == 0) && ($urandom_range(0, 7) == 0);
            step(r, RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), RW'($urandom_range(0, 3)),
                 1'($urandom), bt, ($urandom_range(0, 5) == 0), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
